seq_multiplier: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_step.sv | 20 ++
 rtl/seq_multiplier.sv | 114 +++++++++++
 tb/tb_seq_multiplier.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencing states, datapath width and result-flag type
// used by the Divider and seq_multiplier.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Single-bit overflow/error indication (mulFlag, divFlag).
  typedef logic result_flag_t;

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add iteration; reusable as a stage of an unrolled multiplier.
module mul_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // The full product fits in 2*WIDTH bits, so this sum never wraps.
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mulOut,
  output logic             mulFlag
);

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   out_q;
  result_flag_t       flag_q;

  logic [2*WIDTH-1:0] acc_nx, mcand_nx;
  logic [WIDTH-1:0]   mplier_nx;
  logic               last_iter;
  logic               early;

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_next   (acc_nx),
    .mcand_next (mcand_nx),
    .mplier_next(mplier_nx)
  );

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign early = (mplier_q == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (early || last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, src1};
            mplier_q <= src2;
            count_q  <= '0;
          end
        end
        ST_RUN: begin
          if (early) begin
            // Remaining multiplier bits are all zero: acc already holds the product.
            out_q  <= acc_q[WIDTH-1:0];
            flag_q <= |acc_q[2*WIDTH-1:WIDTH];
          end else begin
            acc_q    <= acc_nx;
            mcand_q  <= mcand_nx;
            mplier_q <= mplier_nx;
            count_q  <= count_q + CNT_W'(1);
            if (last_iter) begin
              out_q  <= acc_nx[WIDTH-1:0];
              flag_q <= |acc_nx[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign mulOut  = out_q;
  assign mulFlag = flag_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver pushes expected results, monitor checks on done.
module tb_seq_multiplier;

  localparam int W = 32;

`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] src1, src2;
  logic         busy, done, mulFlag;
  logic [W-1:0] mulOut;

  seq_multiplier #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .mulOut (mulOut),
    .mulFlag(mulFlag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         flag;
    int           due;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Edges from the acceptance edge to the edge entering DONE.
  function automatic int lat_of(input logic [W-1:0] b);
    int bl = 0;
    for (int i = 0; i < W; i++) if (b[i]) bl = i + 1;
    return (EarlyTerm && (bl + 1 < W)) ? bl + 1 : W;
  endfunction

  // Monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      check("done_busy", {63'b0, busy}, 64'd1);
      check("done_single", {63'b0, prev_done}, 64'd0);
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected no pending op", cyc);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_out"}, {32'b0, mulOut}, {32'b0, e.out});
        check({e.name, "_flag"}, {63'b0, mulFlag}, {63'b0, e.flag});
        check({e.name, "_lat"}, 64'(cyc), 64'(e.due));
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      $display("FAIL idle_timeout: got busy=1, expected busy=0");
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] out,
                       input logic flag, input string name);
    wait_idle();
    src1  = a;
    src2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{out, flag, cyc + lat_of(b), name});
    start = 1'b0;
    src1  = 32'hDEAD_BEEF;
    src2  = 32'h1234_5678;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || busy) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         flag;
    string        name;
  } vec_t;

  vec_t vecs[12] = '{
    '{32'd8,          32'd2,          32'd16,         1'b0, "basic8x2"},
    '{32'd6,          32'd2,          32'd12,         1'b0, "basic6x2"},
    '{32'd4,          32'd2,          32'd8,          1'b0, "basic4x2"},
    '{32'd2,          32'd2,          32'd4,          1'b0, "basic2x2"},
    '{32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFE,  1'b1, "ovf_ffx2"},
    '{32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b1, "ovf_2p32"},
    '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b1, "max_max"},
    '{32'd0,          32'd5,          32'd0,          1'b0, "zero_src1"},
    '{32'd5,          32'd0,          32'd0,          1'b0, "zero_src2"},
    '{32'd9,          32'd1,          32'd9,          1'b0, "one_src2"},
    '{32'd1,          32'h8000_0000,  32'h8000_0000,  1'b0, "msb_src2"},
    '{32'd1234,       32'd5678,       32'd7006652,    1'b0, "mid"}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, l1;
    reset = 1'b1;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_out", {32'b0, mulOut}, 64'd0);
    check("rst_flag", {63'b0, mulFlag}, 64'd0);
    reset = 1'b0;

    // Directed vectors, one at a time
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].flag, vecs[i].name);
      drain();
    end

    // Leave a non-zero result so the reset clearing is observable
    issue(32'd3, 32'd5, 32'd15, 1'b0, "pre_reset");
    drain();

    // Reset in the middle of RUN: outputs clear at once, no done follows
    wait_idle();
    src1  = 32'd8;
    src2  = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_out", {32'b0, mulOut}, 64'd0);
    check("midrst_flag", {63'b0, mulFlag}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (W + 5) @(negedge clk);
    issue(32'd6, 32'd2, 32'd12, 1'b0, "post_reset");
    drain();

    // start pulses during RUN are ignored
    issue(32'd100, 32'd3, 32'd300, 1'b0, "hs_first");
    repeat (2) @(negedge clk);
    src1  = 32'd50;
    src2  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hs_busy3", {63'b0, busy}, 64'd1);
    repeat (6) @(negedge clk);
    src1  = 32'd11;
    src2  = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hs_busy10", {63'b0, busy}, 64'd1);
    drain();

    // Back-to-back with start held high
    wait_idle();
    src1  = 32'd7;
    src2  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    k  = cyc;
    l1 = lat_of(32'd3);
    sbq.push_back('{32'd21, 1'b0, k + l1, "b2b_first"});
    sbq.push_back('{32'd25, 1'b0, k + l1 + 2 + lat_of(32'd5), "b2b_second"});
    src1 = 32'd5;
    src2 = 32'd5;
    while (cyc < k + l1 + 2) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
